bitloc_stream: RTL and testbench

BITLOC_STREAM -- requirements
Module: bitloc_stream

---
 rtl/bitloc_pkg.sv | 27 ++
 rtl/bitloc_enc.sv | 36 +++
 rtl/bitloc_stream.sv | 98 +++++++++
 tb/tb_bitloc_stream.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bitloc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// bitloc_pkg : shared defaults and result-entry type for bitloc_stream
// Rev 1.0
// ---------------------------------------------------------------
package bitloc_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 4;
    localparam bit DEF_MSB_FIRST  = 1'b0;
    localparam int MAX_DATA_WIDTH = 256;

    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Entry index field is sized for the widest supported bus; instances use the low bits.
    localparam int IDX_W_MAX = idx_width(MAX_DATA_WIDTH);

    typedef struct packed {
        logic [IDX_W_MAX-1:0] index;
        logic                 none;
        logic                 multi;
    } bitloc_entry_t;

endpackage
`default_nettype wire

// File: rtl/bitloc_enc.sv
`default_nettype none
// ---------------------------------------------------------------
// bitloc_enc : combinational priority encoder with none/multi flags
// Rev 1.0
// ---------------------------------------------------------------
module bitloc_enc
    import bitloc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter bit MSB_FIRST  = DEF_MSB_FIRST
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    output bitloc_entry_t         entry_o
);

    logic w_found;

    // Scan from the winning end; the first set bit seen owns the index, any later one flags multi.
    always_comb begin
        entry_o = '0;
        w_found = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (data_i[MSB_FIRST ? (DATA_WIDTH - 1 - i) : i]) begin
                if (!w_found) begin
                    entry_o.index = IDX_W_MAX'(MSB_FIRST ? (DATA_WIDTH - 1 - i) : i);
                    w_found       = 1'b1;
                end else begin
                    entry_o.multi = 1'b1;
                end
            end
        end
        entry_o.none = ~w_found;
    end

endmodule
`default_nettype wire

// File: rtl/bitloc_stream.sv
`default_nettype none
// ---------------------------------------------------------------
// bitloc_stream : streaming bit locator with registered result FIFO
// Rev 1.0
// ---------------------------------------------------------------
module bitloc_stream
    import bitloc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter bit MSB_FIRST  = DEF_MSB_FIRST
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         vld_src,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic                         rdy_src,
    output logic [$clog2(DATA_WIDTH)-1:0] index,
    output logic                         none,
    output logic                         multi,
    output logic                         vld_sink,
    input  logic                         rdy_sink,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    bitloc_entry_t    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             en_q;
    logic             w_accept;
    logic             w_pop;
    bitloc_entry_t    w_enc;
    bitloc_entry_t    w_head;
    logic             w_unused_idx;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    bitloc_enc #(
        .DATA_WIDTH (DATA_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_enc (
        .data_i  (data_in),
        .entry_o (w_enc)
    );

    // en_q holds ready low for the first cycle out of reset.
    assign rdy_src  = en_q && (level_q < LVL_W'(DEPTH));
    assign vld_sink = (level_q != '0);
    assign w_accept = vld_src && rdy_src;
    assign w_pop    = vld_sink && rdy_sink;
    assign level    = level_q;

    always_comb begin
        wr_ptr_d = w_accept ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = w_pop    ? next_ptr(rd_ptr_q) : rd_ptr_q;
        level_d  = level_q;
        if (w_accept && !w_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (w_pop && !w_accept) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            en_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            en_q     <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            mem_q[wr_ptr_q] <= w_enc;
        end
    end

    assign w_head       = mem_q[rd_ptr_q];
    assign w_unused_idx = ^w_head.index;
    assign index        = vld_sink ? w_head.index[IDX_W-1:0] : '0;
    assign none         = vld_sink ? w_head.none  : 1'b0;
    assign multi        = vld_sink ? w_head.multi : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_bitloc_stream.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_bitloc_stream : two configurations checked against a queue model
// Rev 1.0
// ---------------------------------------------------------------
module tb_bitloc_stream;

    localparam int DEP [2] = '{4, 3};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld_src = 1'b0;
    logic [7:0] data_in = '0;
    logic [1:0] rdy_sink = '0;
    logic [1:0] rdy_src, vld_sink, none, multi;
    logic [2:0] idx0, idx1, lvl0;
    logic [1:0] lvl1;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;
    logic [7:0] mq [2][$];
    bit men [2];

    always #5 clk = ~clk;

    bitloc_stream #(.DATA_WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .vld_src(vld_src), .data_in(data_in), .rdy_src(rdy_src[0]),
        .index(idx0), .none(none[0]), .multi(multi[0]), .vld_sink(vld_sink[0]),
        .rdy_sink(rdy_sink[0]), .level(lvl0));

    bitloc_stream #(.DATA_WIDTH(8), .DEPTH(3), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .vld_src(vld_src), .data_in(data_in), .rdy_src(rdy_src[1]),
        .index(idx1), .none(none[1]), .multi(multi[1]), .vld_sink(vld_sink[1]),
        .rdy_sink(rdy_sink[1]), .level(lvl1));

    // Result as {index[2:0], none, multi}, from bit arithmetic rather than a scan.
    function automatic logic [4:0] enc(input logic [7:0] w, input bit msb);
        logic [7:0] iso;
        int p;
        if (w == 8'h00) return 5'b000_1_0;
        iso = w & (~w + 8'd1);
        p = msb ? ($clog2({1'b0, w} + 9'd1) - 1) : $clog2(iso);
        return {p[2:0], 1'b0, ($countones(w) >= 2)};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mq[k].delete();
                men[k] = 1'b0;
            end else begin
                bit acc, pp;
                acc = vld_src && men[k] && (mq[k].size() < DEP[k]);
                pp  = (mq[k].size() != 0) && rdy_sink[k];
                if (pp)  void'(mq[k].pop_front());
                if (acc) mq[k].push_back(data_in);
                men[k] = 1'b1;
            end
        end
        if (rst) started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                logic [9:0] got, exp;
                logic [4:0] e;
                e = (mq[k].size() != 0) ? enc(mq[k][0], k == 1) : 5'b0;
                exp = {men[k] && (mq[k].size() < DEP[k]), mq[k].size() != 0, 3'(mq[k].size()), e};
                if (k == 0) got = {rdy_src[0], vld_sink[0], lvl0, idx0, none[0], multi[0]};
                else        got = {rdy_src[1], vld_sink[1], 1'b0, lvl1, idx1, none[1], multi[1]};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL cycle_dut%0d at %0t: got {rdy,vld,lvl,idx,none,multi}=%b required %b",
                             k, $time, got, exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        #3;
        chk("reset_rdy0", rdy_src[0], 0);
        chk("reset_vld0", vld_sink[0], 0);
        chk("reset_level0", lvl0, 0);
        rst = 1'b0;
        step();
        #3;
        chk("rdy_after_reset", rdy_src[0], 1);

        // Single word, then an all-zero word, sink always ready.
        rdy_sink = 2'b11;
        vld_src  = 1'b1;
        data_in  = 8'b0010_1000;
        step();
        data_in  = 8'h00;
        #3;
        chk("lsb_index", idx0, 3);
        chk("lsb_multi", multi[0], 1);
        chk("lsb_none", none[0], 0);
        chk("lsb_vld", vld_sink[0], 1);
        chk("msb_index", idx1, 5);
        chk("msb_multi", multi[1], 1);
        step();
        vld_src = 1'b0;
        #3;
        chk("zero_index", idx1, 0);
        chk("zero_none", none[1], 1);
        chk("zero_multi", multi[1], 0);
        step();
        step();

        // Fill with sink stalled.
        rdy_sink = 2'b00;
        vld_src  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in = 8'(1 << i);
            step();
        end
        #3;
        chk("full_level0", lvl0, 4);
        chk("full_rdy0", rdy_src[0], 0);
        chk("full_level1", lvl1, 3);
        chk("full_head0", idx0, 0);
        rdy_sink = 2'b11;
        step();
        #3;
        chk("pop_only_level", lvl0, 3);
        chk("pop_only_rdy", rdy_src[0], 1);
        step();
        #3;
        chk("acc_pop_level", lvl0, 3);
        vld_src = 1'b0;
        repeat (6) step();

        // Reset with entries held.
        rdy_sink = 2'b00;
        vld_src  = 1'b1;
        data_in  = 8'h81;
        step();
        step();
        vld_src = 1'b0;
        #3;
        chk("pre_rst_level", lvl0, 2);
        rst = 1'b1;
        step();
        #3;
        chk("rst_vld", vld_sink[0], 0);
        chk("rst_level", lvl0, 0);
        chk("rst_rdy", rdy_src[0], 0);
        rst = 1'b0;
        rdy_sink = 2'b11;
        step();
        #3;
        chk("rst_rdy_rise", rdy_src[0], 1);
        chk("rst_no_ghost", vld_sink[0], 0);

        for (int n = 0; n < 500; n++) begin
            vld_src = ($urandom % 4) != 0;
            case ($urandom % 4)
                0:       data_in = 8'h00;
                1:       data_in = 8'(1 << ($urandom % 8));
                default: data_in = 8'($urandom);
            endcase
            rdy_sink = 2'($urandom);
            rst = (($urandom % 60) == 0);
            step();
        end
        rst = 1'b0;
        vld_src = 1'b0;
        rdy_sink = 2'b11;
        repeat (8) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
